// File: rtl/voice_slot_if.sv
// Command-in / slot-out bundle of the voice slot scheduler.
// Parameterised on voice count so slot_voice width tracks it.
interface voice_slot_if #(
  parameter int NUM_VOICES = 16
);
  localparam int VW = $clog2(NUM_VOICES);

  logic          cmd_ready_flag;
  logic          cmd_note_status;
  logic [7:0]    cmd_voice_index;
  logic [6:0]    cmd_midi_note;
  logic [6:0]    cmd_velocity;

  logic          slot_start;
  logic          frame_start;
  logic [VW-1:0] slot_voice;
  logic          slot_active;
  logic [6:0]    slot_note;
  logic [6:0]    slot_velocity;
  logic          slot_gate_on;
  logic          slot_gate_off;
  logic          sweep_busy;
  logic          cmd_dropped;

  modport master (
    output cmd_ready_flag, cmd_note_status,
    output cmd_voice_index, cmd_midi_note,
    output cmd_velocity,
    input  slot_start, frame_start, slot_voice,
    input  slot_active, slot_note, slot_velocity,
    input  slot_gate_on, slot_gate_off,
    input  sweep_busy, cmd_dropped
  );

  modport slave (
    input  cmd_ready_flag, cmd_note_status,
    input  cmd_voice_index, cmd_midi_note,
    input  cmd_velocity,
    output slot_start, frame_start, slot_voice,
    output slot_active, slot_note, slot_velocity,
    output slot_gate_on, slot_gate_off,
    output sweep_busy, cmd_dropped
  );
endinterface

// File: rtl/voice_slot_scheduler.sv
// Note commands -> per-voice table; round-robin slot scanner
// presenting one voice per slot, plus all-notes-off sweep.
module voice_slot_scheduler #(
  parameter int NUM_VOICES  = 16,
  parameter int SLOT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  voice_slot_if.slave bus
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SWEEP = 1'b1;
  localparam logic [7:0]    ALL_OFF  = 8'hFF;
  localparam logic [VW-1:0] LAST_V   = VW'(NUM_VOICES - 1);
  localparam logic [CW-1:0] LAST_S   = CW'(SLOT_CYCLES - 1);

  logic          ready_d;
  logic          pend_full;
  logic          pend_on;
  logic [7:0]    pend_idx;
  logic [6:0]    pend_note;
  logic [6:0]    pend_vel;
  logic [0:0]    state;
  logic [VW-1:0] sweep_idx;
  logic [CW-1:0] slot_cnt;
  logic [VW-1:0] voice_cnt;
  logic          dropped_q;

  logic          t_active [NUM_VOICES];
  logic [6:0]    t_note   [NUM_VOICES];
  logic [6:0]    t_vel    [NUM_VOICES];
  logic          t_pon    [NUM_VOICES];
  logic          t_poff   [NUM_VOICES];

  logic          rise;
  logic          bad_idx;
  logic          apply;
  logic          accept;
  logic          sweeping;
  logic          apply_note;
  logic          sweep_start;
  logic          wrap;
  logic [VW-1:0] next_voice;
  logic          wr_en;
  logic          wr_set;
  logic [VW-1:0] wr_idx;

  assign rise     = bus.cmd_ready_flag & ~ready_d;
  assign bad_idx  = (bus.cmd_voice_index >= 8'(NUM_VOICES))
                  && (bus.cmd_voice_index != ALL_OFF);
  assign sweeping = (state == ST_SWEEP);
  assign apply    = pend_full && !sweeping;
  // A rise landing on the edge that empties pending is taken.
  assign accept   = rise && !bad_idx && (!pend_full || apply);
  assign apply_note  = apply && (pend_idx != ALL_OFF);
  assign sweep_start = apply && (pend_idx == ALL_OFF);
  assign wrap        = (slot_cnt == LAST_S);
  assign next_voice  = voice_cnt + VW'(1);

  // Select the single table write for this cycle.
  always_comb begin
    wr_en  = 1'b0;
    wr_set = 1'b0;
    wr_idx = '0;
    unique case (1'b1)
      sweeping: begin
        wr_en  = 1'b1;
        wr_idx = sweep_idx;
      end
      apply_note: begin
        wr_en  = 1'b1;
        wr_idx = pend_idx[VW-1:0];
        wr_set = pend_on && (pend_vel != 7'd0);
      end
      default: ;
    endcase
  end

  // Edge detect, pending register, sweep FSM, drop pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_d   <= 1'b0;
      pend_full <= 1'b0;
      pend_on   <= 1'b0;
      pend_idx  <= '0;
      pend_note <= '0;
      pend_vel  <= '0;
      state     <= ST_IDLE;
      sweep_idx <= '0;
      dropped_q <= 1'b0;
    end else begin
      ready_d   <= bus.cmd_ready_flag;
      dropped_q <= rise && !accept;
      if (accept) begin
        pend_full <= 1'b1;
        pend_on   <= bus.cmd_note_status;
        pend_idx  <= bus.cmd_voice_index;
        pend_note <= bus.cmd_midi_note;
        pend_vel  <= bus.cmd_velocity;
      end else if (apply) begin
        pend_full <= 1'b0;
      end
      if (sweeping) begin
        sweep_idx <= sweep_idx + VW'(1);
        if (sweep_idx == LAST_V) state <= ST_IDLE;
      end else if (sweep_start) begin
        state     <= ST_SWEEP;
        sweep_idx <= '0;
      end
    end
  end

  // Voice table; writes after the capture clear so their flags win.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        t_active[i] <= 1'b0;
        t_note[i]   <= '0;
        t_vel[i]    <= '0;
        t_pon[i]    <= 1'b0;
        t_poff[i]   <= 1'b0;
      end
    end else begin
      if (wrap) begin
        t_pon[next_voice]  <= 1'b0;
        t_poff[next_voice] <= 1'b0;
      end
      if (wr_en) begin
        if (wr_set) begin
          t_active[wr_idx] <= 1'b1;
          t_note[wr_idx]   <= pend_note;
          t_vel[wr_idx]    <= pend_vel;
          t_pon[wr_idx]    <= 1'b1;
          t_poff[wr_idx]   <= 1'b0;
        end else begin
          t_active[wr_idx] <= 1'b0;
          t_note[wr_idx]   <= '0;
          t_vel[wr_idx]    <= '0;
          t_pon[wr_idx]    <= 1'b0;
          if (t_active[wr_idx]) t_poff[wr_idx] <= 1'b1;
        end
      end
    end
  end

  // Slot scanner and per-slot output capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt          <= LAST_S;
      voice_cnt         <= LAST_V;
      bus.slot_voice    <= '0;
      bus.slot_active   <= 1'b0;
      bus.slot_note     <= '0;
      bus.slot_velocity <= '0;
      bus.slot_gate_on  <= 1'b0;
      bus.slot_gate_off <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
      if (wrap) begin
        voice_cnt         <= next_voice;
        bus.slot_voice    <= next_voice;
        bus.slot_active   <= t_active[next_voice];
        bus.slot_note     <= t_note[next_voice];
        bus.slot_velocity <= t_vel[next_voice];
        bus.slot_gate_on  <= t_pon[next_voice];
        bus.slot_gate_off <= t_poff[next_voice];
      end
    end
  end

  assign bus.slot_start  = (slot_cnt == '0);
  assign bus.frame_start = bus.slot_start && (voice_cnt == '0);
  assign bus.sweep_busy  = sweeping;
  assign bus.cmd_dropped = dropped_q;
endmodule

// File: tb/tb_voice_slot_scheduler.sv
// Directed bench for voice_slot_scheduler, 4 voices x 4 cycles.
// Vector table for single commands, hand sequences for sweeps.
module tb_voice_slot_scheduler;
  localparam int NV = 4;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  voice_slot_if #(.NUM_VOICES(NV)) bus();

  voice_slot_scheduler #(
    .NUM_VOICES (NV),
    .SLOT_CYCLES(SC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_cmd;
    logic [7:0] cv;
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    int         obs;
    logic       drop;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] pk(
    input logic a, input logic [6:0] n,
    input logic [6:0] v, input logic gon, input logic goff);
    return {a, n, v, gon, goff};
  endfunction

  function automatic logic [16:0] sd();
    return {bus.slot_active, bus.slot_note, bus.slot_velocity,
            bus.slot_gate_on, bus.slot_gate_off};
  endfunction

  function automatic logic [22:0] all_out();
    return {bus.slot_start, bus.frame_start, bus.slot_voice,
            sd(), bus.sweep_busy, bus.cmd_dropped};
  endfunction

  function automatic vec_t mk(
    input logic c, input logic [7:0] cv, input logic on,
    input logic [6:0] n, input logic [6:0] v, input int obs,
    input logic drop, input logic [16:0] exp);
    vec_t r;
    r.is_cmd = c; r.cv = cv; r.on = on; r.note = n;
    r.vel = v; r.obs = obs; r.drop = drop; r.exp = exp;
    return r;
  endfunction

  task automatic set_cmd(input logic [7:0] v, input logic on,
                         input logic [6:0] n, input logic [6:0] vel);
    bus.cmd_voice_index = v;
    bus.cmd_note_status = on;
    bus.cmd_midi_note   = n;
    bus.cmd_velocity    = vel;
    bus.cmd_ready_flag  = 1'b1;
  endtask

  task automatic send(input logic [7:0] v, input logic on,
                      input logic [6:0] n, input logic [6:0] vel,
                      output logic dropped);
    set_cmd(v, on, n, vel);
    tick();
    dropped = bus.cmd_dropped;
    bus.cmd_ready_flag = 1'b0;
    tick();
  endtask

  task automatic wait_voice(input int v, output logic ok);
    int k;
    k  = 0;
    ok = 1'b0;
    while (!ok && k < 64) begin
      tick();
      k++;
      if (bus.slot_start && int'(bus.slot_voice) == v) ok = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic drp;
    int   busy;
    int   seen;
    logic [16:0] e;

    vecs[0]  = mk(1, 8'd2, 1, 7'd60, 7'd100, 2, 0, pk(1, 60, 100, 1, 0));
    vecs[1]  = mk(0, 8'd0, 0, 7'd0, 7'd0, 2, 0, pk(1, 60, 100, 0, 0));
    vecs[2]  = mk(1, 8'd2, 0, 7'd60, 7'd0, 2, 0, pk(0, 0, 0, 0, 1));
    vecs[3]  = mk(1, 8'd2, 0, 7'd60, 7'd0, 2, 0, pk(0, 0, 0, 0, 0));
    vecs[4]  = mk(1, 8'd1, 1, 7'd64, 7'd80, 1, 0, pk(1, 64, 80, 1, 0));
    vecs[5]  = mk(1, 8'd1, 1, 7'd64, 7'd0, 1, 0, pk(0, 0, 0, 0, 1));
    vecs[6]  = mk(1, 8'd9, 1, 7'd70, 7'd90, 1, 1, pk(0, 0, 0, 0, 0));
    vecs[7]  = mk(1, 8'd0, 1, 7'd127, 7'd127, 0, 0,
                  pk(1, 127, 127, 1, 0));
    vecs[8]  = mk(1, 8'd3, 1, 7'd0, 7'd1, 3, 0, pk(1, 0, 1, 1, 0));
    vecs[9]  = mk(1, 8'd3, 1, 7'd5, 7'd9, 3, 0, pk(1, 5, 9, 1, 0));
    vecs[10] = mk(0, 8'd0, 0, 7'd0, 7'd0, 0, 0,
                  pk(1, 127, 127, 0, 0));
    vecs[11] = mk(1, 8'd4, 1, 7'd1, 7'd1, 0, 1,
                  pk(1, 127, 127, 0, 0));

    bus.cmd_ready_flag  = 1'b0;
    bus.cmd_note_status = 1'b0;
    bus.cmd_voice_index = '0;
    bus.cmd_midi_note   = '0;
    bus.cmd_velocity    = '0;

    reset = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", 32'(all_out()), 32'd0);
    reset = 1'b0;

    for (int k = 1; k <= 40; k++) begin
      logic       es;
      logic       ef;
      logic [1:0] ev;
      tick();
      es = ((k - 1) % 4) == 0;
      ef = ((k - 1) % 16) == 0;
      ev = 2'(((k - 1) / 4) % 4);
      chk($sformatf("idle_c%0d", k), 32'(all_out()),
          32'({es, ef, ev, 17'd0, 2'd0}));
    end

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_cmd) begin
        send(vecs[i].cv, vecs[i].on, vecs[i].note, vecs[i].vel, drp);
        chk($sformatf("vec%0d_drop", i), 32'(drp), 32'(vecs[i].drop));
      end
      wait_voice(vecs[i].obs, ok);
      chk($sformatf("vec%0d_wait", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_slot", i), 32'(sd()), 32'(vecs[i].exp));
    end

    for (int v = 0; v < 4; v++) begin
      send(8'(v), 1'b1, 7'(10 + v), 7'(20 + v), drp);
    end
    wait_voice(3, ok);
    chk("sweep_sync", 32'(ok), 32'd1);
    tick();
    tick();
    set_cmd(8'hFF, 1'b0, 7'd0, 7'd0);
    busy = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) bus.cmd_ready_flag = 1'b0;
      if (i == 1) set_cmd(8'd3, 1'b1, 7'd72, 7'd50);
      if (i == 2) bus.cmd_ready_flag = 1'b0;
      if (bus.sweep_busy) busy++;
      if (i >= 5 && bus.slot_start && seen < 4) begin
        if (bus.slot_voice == 2'd3) e = pk(1, 72, 50, 1, 0);
        else e = pk(0, 0, 0, 0, 1);
        chk($sformatf("sweep_v%0d", bus.slot_voice), 32'(sd()),
            32'(e));
        seen++;
      end
    end
    chk("sweep_busy_cycles", busy, 4);
    chk("sweep_slots_seen", seen, 4);

    set_cmd(8'hFF, 1'b1, 7'd0, 7'd0);
    tick();
    chk("sweep2_accept", 32'(bus.cmd_dropped), 32'd0);
    bus.cmd_ready_flag = 1'b0;
    tick();
    chk("sweep2_busy", 32'(bus.sweep_busy), 32'd1);
    set_cmd(8'd0, 1'b1, 7'd33, 7'd44);
    tick();
    chk("rise1_drop", 32'(bus.cmd_dropped), 32'd0);
    bus.cmd_ready_flag = 1'b0;
    tick();
    bus.cmd_ready_flag = 1'b1;
    tick();
    chk("rise2_drop", 32'(bus.cmd_dropped), 32'd1);
    chk("rise2_busy", 32'(bus.sweep_busy), 32'd1);
    bus.cmd_ready_flag = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("midsweep_reset", 32'(all_out()), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_reset_first", 32'({bus.slot_start, bus.frame_start,
        bus.slot_voice}), 32'({1'b1, 1'b1, 2'd0}));
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("post_reset_slot%0d", s),
          32'({sd(), bus.sweep_busy}), 32'd0);
      repeat (4) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
